// File: rtl/multicycle_ctrl_pkg.sv
// rv_ctrl_pkg: shared encodings for the RV32I multi-cycle control sequencer.
// Holds the opcode constants, FSM state type, ALU operation codes,
// writeback/branch select encodings, the instruction class type and a
// helper that says whether an opcode is one the sequencer can execute.
package rv_ctrl_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_e;

  typedef enum logic [3:0] {
    ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4, XOR = 4'd5,
    SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9, PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {WB_MEM = 2'b00, WB_ALU = 2'b01, WB_PC = 2'b10} wb_sel_e;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_BLTU = 3'b101;
  localparam logic [2:0] BR_BGEU = 3'b110;
  localparam logic [2:0] BR_JUMP = 3'b111;

  typedef enum logic [2:0] {
    CL_NONE, CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP
  } instr_class_e;

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM, LUI, AUIPC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundle between the control sequencer and the datapath.
//   master : the sequencer (takes opcode/f3/f7/stall/mem_ready, drives strobes)
//   slave  : the datapath side (drives decode fields and handshakes)
// With CTRL_PERF_EN defined the bundle also carries the instret/cycles
// performance counters (CNT_W bits); otherwise they do not exist.
interface multicycle_ctrl_if
`ifdef CTRL_PERF_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  import rv_ctrl_pkg::*;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       stall;
  logic       mem_ready;

  logic       pc_en;
  logic       ir_en;
  logic       reg_wr;
  logic       mem_rd;
  logic       mem_wr;
  wb_sel_e    wb_ctrl;
  alu_op_e    alu_op;
  logic       alu_s1;
  logic       alu_s2;
  logic [2:0] branch_ctrl;
  logic [2:0] mem_ctrl;
  logic       illegal;
  logic       bus_err;
`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] instret;
  logic [CNT_W-1:0] cycles;
`endif

  modport master (
    input  opcode, f3, f7, stall, mem_ready,
`ifdef CTRL_PERF_EN
    output instret, cycles,
`endif
    output pc_en, ir_en, reg_wr, mem_rd, mem_wr, wb_ctrl, alu_op, alu_s1,
           alu_s2, branch_ctrl, mem_ctrl, illegal, bus_err
  );

  modport slave (
    output opcode, f3, f7, stall, mem_ready,
`ifdef CTRL_PERF_EN
    input  instret, cycles,
`endif
    input  pc_en, ir_en, reg_wr, mem_rd, mem_wr, wb_ctrl, alu_op, alu_s1,
           alu_s2, branch_ctrl, mem_ctrl, illegal, bus_err
  );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_decode: combinational instruction decoder for the sequencer.
// Inputs : latched opcode, f3 and the f7 "alternate" bit (f7[5]).
// Outputs: alu_op, alu_s1 (1=PC), alu_s2 (1=imm), branch_ctrl, wb_ctrl,
//          instruction class and legal flag.
module ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   f3,
  input  logic         f7_alt,
  output alu_op_e      alu_op,
  output logic         alu_s1,
  output logic         alu_s2,
  output logic [2:0]   branch_ctrl,
  output wb_sel_e      wb_ctrl,
  output instr_class_e cls,
  output logic         legal
);

  alu_op_e f3_op;

  always_comb begin
    case (f3)
      3'b000:  f3_op = ADD;
      3'b001:  f3_op = SLL;
      3'b010:  f3_op = SLT;
      3'b011:  f3_op = SLTU;
      3'b100:  f3_op = XOR;
      3'b101:  f3_op = SRL;
      3'b110:  f3_op = OR;
      default: f3_op = AND;
    endcase
  end

  always_comb begin
    alu_op      = ADD;
    alu_s1      = 1'b0;
    alu_s2      = 1'b0;
    branch_ctrl = BR_NONE;
    wb_ctrl     = WB_ALU;
    cls         = CL_NONE;
    legal       = opcode_legal(opcode);
    case (opcode)
      OP: begin
        cls    = CL_ALU;
        alu_op = f3_op;
        if (f7_alt && f3 == 3'b000) alu_op = SUB;
        if (f7_alt && f3 == 3'b101) alu_op = SRA;
      end
      OP_IMM: begin
        // f7 only carries meaning for the shift-right-immediate pair.
        cls    = CL_ALU;
        alu_s2 = 1'b1;
        alu_op = f3_op;
        if (f7_alt && f3 == 3'b101) alu_op = SRA;
      end
      LUI: begin
        cls    = CL_ALU;
        alu_op = PASS_B;
        alu_s2 = 1'b1;
      end
      AUIPC: begin
        cls    = CL_ALU;
        alu_s1 = 1'b1;
        alu_s2 = 1'b1;
      end
      LOAD: begin
        cls     = CL_LOAD;
        alu_s2  = 1'b1;
        wb_ctrl = WB_MEM;
      end
      STORE: begin
        cls    = CL_STORE;
        alu_s2 = 1'b1;
      end
      BRANCH: begin
        cls    = CL_BRANCH;
        alu_op = SUB;
        case (f3)
          3'b000:  branch_ctrl = BR_BEQ;
          3'b001:  branch_ctrl = BR_BNE;
          3'b100:  branch_ctrl = BR_BLT;
          3'b101:  branch_ctrl = BR_BGE;
          3'b110:  branch_ctrl = BR_BLTU;
          3'b111:  branch_ctrl = BR_BGEU;
          default: branch_ctrl = BR_NONE;
        endcase
      end
      JAL: begin
        cls         = CL_JUMP;
        alu_s1      = 1'b1;
        alu_s2      = 1'b1;
        branch_ctrl = BR_JUMP;
        wb_ctrl     = WB_PC;
      end
      JALR: begin
        cls         = CL_JUMP;
        alu_s2      = 1'b1;
        branch_ctrl = BR_JUMP;
        wb_ctrl     = WB_PC;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control sequencer for the RV32I datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives all
// datapath controls plus PC/IR enables, waits on mem_ready and traps on
// illegal opcodes or a data-memory timeout (TRAP is left only by reset).
// Ports: clk, reset (async, active-low), bus (multicycle_ctrl_if.master).
// Parameters: MEM_TIMEOUT (MEM cycles before bus error), CNT_W (perf).
// Optional: define CTRL_PERF_EN to add the instret/cycles counters.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [6:0]        opcode_q;
  logic [2:0]        f3_q;
  logic              f7_alt_q;   // only f7[5] influences decode
  logic              illegal_q;
  logic              bus_err_q;

  alu_op_e      dec_alu_op;
  logic         dec_s1;
  logic         dec_s2;
  logic [2:0]   dec_br;
  wb_sel_e      dec_wb;
  instr_class_e dec_cls;
  logic         dec_legal;

  ctrl_decode u_decode (
    .opcode      (opcode_q),
    .f3          (f3_q),
    .f7_alt      (f7_alt_q),
    .alu_op      (dec_alu_op),
    .alu_s1      (dec_s1),
    .alu_s2      (dec_s2),
    .branch_ctrl (dec_br),
    .wb_ctrl     (dec_wb),
    .cls         (dec_cls),
    .legal       (dec_legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      opcode_q  <= '0;
      f3_q      <= '0;
      f7_alt_q  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      case (state)
        FETCH: if (!bus.stall) state <= DECODE;
        DECODE: begin
          opcode_q <= bus.opcode;
          f3_q     <= bus.f3;
          f7_alt_q <= bus.f7[5];
          // The latched copy is not visible until EXEC, so legality is
          // judged on the live opcode here.
          if (opcode_legal(bus.opcode)) begin
            state <= EXEC;
          end else begin
            state     <= TRAP;
            illegal_q <= 1'b1;
          end
        end
        EXEC: begin
          wait_cnt <= '0;
          if (!dec_legal) begin
            state     <= TRAP;
            illegal_q <= 1'b1;
          end else begin
            case (dec_cls)
              CL_BRANCH:        state <= FETCH;
              CL_LOAD, CL_STORE: state <= MEM;
              CL_ALU, CL_JUMP:  state <= WB;
              default: begin
                state     <= TRAP;
                illegal_q <= 1'b1;
              end
            endcase
          end
        end
        MEM: begin
          // Ready is tested first so a response in the final allowed
          // cycle still completes the access.
          if (bus.mem_ready) begin
            if (dec_cls == CL_LOAD) state <= WB;
            else                    state <= FETCH;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= TRAP;
            bus_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        WB:      state <= FETCH;
        default: state <= TRAP;
      endcase
    end
  end

  // Strobes decode from the state register and the latched instruction.
  // ir_en is gated by reset because FETCH is also the reset state.
  always_comb begin
    bus.pc_en       = 1'b0;
    bus.ir_en       = 1'b0;
    bus.reg_wr      = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.wb_ctrl     = WB_MEM;
    bus.alu_op      = ADD;
    bus.alu_s1      = 1'b0;
    bus.alu_s2      = 1'b0;
    bus.branch_ctrl = BR_NONE;
    bus.mem_ctrl    = 3'b000;
    case (state)
      FETCH: bus.ir_en = reset & ~bus.stall;
      EXEC: begin
        bus.alu_op      = dec_alu_op;
        bus.alu_s1      = dec_s1;
        bus.alu_s2      = dec_s2;
        bus.branch_ctrl = dec_br;
        bus.pc_en       = (dec_cls == CL_BRANCH) || (dec_cls == CL_JUMP);
      end
      MEM: begin
        bus.mem_rd   = (dec_cls == CL_LOAD);
        bus.mem_wr   = (dec_cls == CL_STORE);
        bus.mem_ctrl = f3_q;
        bus.pc_en    = (dec_cls == CL_STORE) && bus.mem_ready;
      end
      WB: begin
        bus.reg_wr  = 1'b1;
        bus.wb_ctrl = dec_wb;
        bus.pc_en   = (dec_cls != CL_JUMP);
      end
      default: ;
    endcase
    bus.illegal = illegal_q;
    bus.bus_err = bus_err_q;
  end

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] cycles_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q <= '0;
      cycles_q  <= '0;
    end else begin
      cycles_q <= cycles_q + CNT_W'(1);
      if (bus.pc_en) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign bus.instret = instret_q;
  assign bus.cycles  = cycles_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench for multicycle_ctrl. A per-instruction
// trace model builds the expected output vector for every cycle from the
// instruction class and memory wait count; one negedge process compares
// it with the DUT. Literal checks pin latencies and pulse counts.
module tb_multicycle_ctrl;
  import rv_ctrl_pkg::*;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic       pc_en;
    logic       ir_en;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] wb;
    logic [3:0] alu;
    logic       s1;
    logic       s2;
    logic [2:0] br;
    logic [2:0] mc;
    logic       ill;
    logic       berr;
  } out_t;

  // ALU op per f3 (ADD SLL SLT SLTU XOR SRL OR AND) and branch code per f3.
  localparam logic [3:0] F3_ALU [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
  localparam logic [2:0] F3_BR  [8] = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6};

  logic clk = 1'b0;
  logic reset;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  out_t  exp_v, care_v, cmp_a;
  bit    chk_en = 1'b0;
  int    rel_cyc;
  string tag = "idle";
  int    n_pc, n_rw, n_mr, n_mw, n_ir, pc_cyc, rw_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic out_t act_out();
    out_t a;
    a.pc_en  = bus.pc_en;
    a.ir_en  = bus.ir_en;
    a.reg_wr = bus.reg_wr;
    a.mem_rd = bus.mem_rd;
    a.mem_wr = bus.mem_wr;
    a.wb     = bus.wb_ctrl;
    a.alu    = bus.alu_op;
    a.s1     = bus.alu_s1;
    a.s2     = bus.alu_s2;
    a.br     = bus.branch_ctrl;
    a.mc     = bus.mem_ctrl;
    a.ill    = bus.illegal;
    a.berr   = bus.bus_err;
    return a;
  endfunction

  // Class codes: 0 illegal, 1 alu, 2 load, 3 store, 4 branch, 5 jump.
  task automatic model(input logic [6:0] op, input logic [2:0] f3v, input logic [6:0] f7v,
                       output int cls, output logic [3:0] alu, output logic s1,
                       output logic s2, output logic [2:0] br, output logic [1:0] wb);
    cls = 0; alu = 4'd0; s1 = 1'b0; s2 = 1'b0; br = 3'd0; wb = 2'b01;
    case (op)
      OP:     begin cls = 1; alu = F3_ALU[f3v];
                    if (f7v[5] && (f3v == 3'd0 || f3v == 3'd5)) alu = alu + 4'd1; end
      OP_IMM: begin cls = 1; s2 = 1'b1; alu = F3_ALU[f3v];
                    if (f7v[5] && f3v == 3'd5) alu = alu + 4'd1; end
      LUI:    begin cls = 1; s2 = 1'b1; alu = 4'd10; end
      AUIPC:  begin cls = 1; s1 = 1'b1; s2 = 1'b1; end
      LOAD:   begin cls = 2; s2 = 1'b1; wb = 2'b00; end
      STORE:  begin cls = 3; s2 = 1'b1; end
      BRANCH: begin cls = 4; br = F3_BR[f3v]; end
      JAL, JALR: begin cls = 5; br = 3'b111; wb = 2'b10; end
      default: cls = 0;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_a = act_out();
      chk($sformatf("%s_c%0d", tag, rel_cyc), 32'(cmp_a & care_v), 32'(exp_v & care_v));
      if (cmp_a.pc_en)  begin n_pc++; pc_cyc = rel_cyc; end
      if (cmp_a.reg_wr) begin n_rw++; rw_cyc = rel_cyc; end
      if (cmp_a.mem_rd) n_mr++;
      if (cmp_a.mem_wr) n_mw++;
      if (cmp_a.ir_en)  n_ir++;
    end
  end

  task automatic cyc(input out_t e, input out_t c);
    exp_v  = e;
    care_v = c;
    chk_en = 1'b1;
    rel_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_instr(input string name, input logic [6:0] op,
                             input logic [2:0] f3v, input logic [6:0] f7v);
    tag = name; rel_cyc = 0;
    n_pc = 0; n_rw = 0; n_mr = 0; n_mw = 0; n_ir = 0; pc_cyc = 0; rw_cyc = 0;
    bus.opcode = op; bus.f3 = f3v; bus.f7 = f7v; bus.mem_ready = 1'b0;
  endtask

  // w: MEM cycles before mem_ready (-1 = never). nstall: FETCH stall cycles.
  task automatic do_instr(input string name, input logic [6:0] op, input logic [2:0] f3v,
                          input logic [6:0] f7v, input int w, input int nstall);
    int cls; logic [3:0] alu; logic s1, s2; logic [2:0] br; logic [1:0] wb;
    out_t e, c; bit done;
    model(op, f3v, f7v, cls, alu, s1, s2, br, wb);
    start_instr(name, op, f3v, f7v);
    c = '1;
    bus.stall = 1'b1;
    for (int i = 0; i < nstall; i++) begin e = '0; cyc(e, c); end
    bus.stall = 1'b0;
    e = '0; e.ir_en = 1'b1; cyc(e, c);
    e = '0; cyc(e, c);
    if (cls == 0) begin
      for (int i = 0; i < 20; i++) begin e = '0; e.ill = 1'b1; cyc(e, c); end
      return;
    end
    e = '0; e.alu = alu; e.s1 = s1; e.s2 = s2; e.br = br;
    e.pc_en = (cls == 4 || cls == 5);
    if (cls == 4 || cls == 5) begin c.alu = '0; c.s1 = 1'b0; c.s2 = 1'b0; end
    cyc(e, c);
    c = '1;
    if (cls == 4) return;
    if (cls == 2 || cls == 3) begin
      done = 1'b0;
      for (int i = 0; i < TIMEOUT && !done; i++) begin
        bus.mem_ready = (i == w);
        e = '0; e.mem_rd = (cls == 2); e.mem_wr = (cls == 3); e.mc = f3v;
        e.pc_en = (cls == 3) && (i == w);
        cyc(e, c);
        done = (i == w);
      end
      bus.mem_ready = 1'b0;
      if (!done) begin
        for (int i = 0; i < 4; i++) begin e = '0; e.berr = 1'b1; cyc(e, c); end
        return;
      end
      if (cls == 3) return;
    end
    e = '0; e.reg_wr = 1'b1; e.wb = wb; e.pc_en = (cls != 5); cyc(e, c);
  endtask

  task automatic do_reset(input string name);
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    chk({name, "_all_zero"}, 32'(act_out()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    out_t e, c;
    reset = 1'b0; bus.stall = 1'b0; bus.mem_ready = 1'b0;
    bus.opcode = '0; bus.f3 = '0; bus.f7 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(act_out()), 32'd0);
    reset = 1'b1;

    do_instr("add1", OP, 3'b000, 7'b0000000, -1, 0);
    chk("add_pc_cyc", pc_cyc, 4);
    chk("add_rw_cnt", n_rw, 1);
    chk("add_rw_cyc", rw_cyc, 4);
    do_instr("add2", OP, 3'b000, 7'b0000000, -1, 0);
    do_instr("add3", OP, 3'b000, 7'b0000000, -1, 0);
`ifdef CTRL_PERF_EN
    chk("perf_instret", bus.instret, 32'd3);
    chk("perf_cycles", bus.cycles, 32'd12);
`endif

    do_instr("sub", OP, 3'b000, 7'b0100000, -1, 0);
    do_instr("sra", OP, 3'b101, 7'b0100000, -1, 0);
    do_instr("addi_f7", OP_IMM, 3'b000, 7'b0100000, -1, 0);
    do_instr("srai", OP_IMM, 3'b101, 7'b0100000, -1, 0);
    do_instr("lui", LUI, 3'b000, 7'b0000000, -1, 0);
    do_instr("auipc", AUIPC, 3'b000, 7'b0000000, -1, 0);

    do_instr("lw_w3", LOAD, 3'b010, 7'b0000000, 3, 0);
    chk("lw_memrd_cnt", n_mr, 4);
    chk("lw_rw_cyc", rw_cyc, 8);
    chk("lw_pc_cyc", pc_cyc, 8);

    do_instr("sw_w0", STORE, 3'b010, 7'b0000000, 0, 0);
    chk("sw_pc_cyc", pc_cyc, 4);
    chk("sw_rw_cnt", n_rw, 0);

    do_instr("lb_w15", LOAD, 3'b000, 7'b0000000, TIMEOUT - 1, 0);
    chk("lb_ready_wins_memrd", n_mr, 16);
    chk("lb_ready_wins_rw_cyc", rw_cyc, 20);

    do_instr("bne", BRANCH, 3'b001, 7'b0000000, -1, 0);
    chk("bne_pc_cyc", pc_cyc, 3);
    chk("bne_rw_cnt", n_rw, 0);

    do_instr("jal", JAL, 3'b000, 7'b0000000, -1, 0);
    chk("jal_pc_cyc", pc_cyc, 3);
    chk("jal_pc_cnt", n_pc, 1);
    chk("jal_rw_cyc", rw_cyc, 4);
    do_instr("jalr", JALR, 3'b000, 7'b0000000, -1, 0);

    do_instr("add_stall", OP, 3'b000, 7'b0000000, -1, 5);
    chk("stall_ir_cnt", n_ir, 1);
    chk("stall_pc_cyc", pc_cyc, 9);

    do_instr("sw_timeout", STORE, 3'b010, 7'b0000000, -1, 0);
    chk("sw_to_memwr_cnt", n_mw, 16);
    chk("sw_to_pc_cnt", n_pc, 0);
    chk("sw_to_bus_err", bus.bus_err, 1);
    do_reset("sw_to_reset");

    do_instr("illegal", 7'b1111111, 3'b000, 7'b0000000, -1, 0);
    chk("ill_flag", bus.illegal, 1);
    chk("ill_pc_cnt", n_pc, 0);
    chk("ill_ir_cnt", n_ir, 1);
    do_reset("ill_reset");

    // Reset pulse in the middle of a load's MEM wait.
    start_instr("lw_rst", LOAD, 3'b010, 7'b0000000);
    c = '1;
    e = '0; e.ir_en = 1'b1; cyc(e, c);
    e = '0; cyc(e, c);
    e = '0; e.alu = 4'd0; e.s2 = 1'b1; cyc(e, c);
    e = '0; e.mem_rd = 1'b1; e.mc = 3'b010; cyc(e, c);
    chk_en = 1'b0;
    #1;
    chk("lw_rst_memrd_before", bus.mem_rd, 1);
    reset = 1'b0;
    #1;
    chk("lw_rst_memrd_drop", bus.mem_rd, 0);
    chk("lw_rst_all_zero", 32'(act_out()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("lw_rst_no_wb", n_rw, 0);
    do_instr("add_after_rst", OP, 3'b000, 7'b0000000, -1, 0);
    chk("restart_ir_cnt", n_ir, 1);
    chk("restart_pc_cyc", pc_cyc, 4);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
